hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that consumes the decode- and execute-side register and control fields, and drives the stall/flush inputs of the pipeline registers (including `flush` of the ID/EX register) and the EX-stage forwarding selects. It combines load-use and branch/jump hazard logic with a one-entry scoreboard for a multi-cycle EX unit (mul/div class). The multi-cycle unit captures its operands on launch and writes back independently. Hazard controls are combinational from inputs plus registered state. Scoreboard, timeout counter and performance counters are sequential.

## Interface
Parameters:
- `MC_TIMEOUT`, 64: max cycles in BUSY before abort; range 2..1023.
- `CNT_W`, 32: width of performance counters.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rs1_D`, `rs2_D`, `rd_D` in 5: decode-stage register indices.
- `mc_op_D` in 1: decode instruction is a multi-cycle op.
- `rs1_E`, `rs2_E`, `rd_E` in 5: execute-stage indices.
- `resultSrc_E` in 2: `2'b01` marks a load.
- `mc_start_E` in 1: multi-cycle op is in EX this cycle (launch).
- `pcSrc_E` in 1: taken branch or jump resolved in EX.
- `rd_M`, `rd_W` in 5; `regWrite_M`, `regWrite_W` in 1: later-stage writers.
- `mc_done` in 1: multi-cycle unit result written back this cycle.
- `stall_F`, `stall_D` out 1: hold PC and IF/ID.
- `flush_D`, `flush_E` out 1: clear IF/ID and ID/EX.
- `forwardA_E`, `forwardB_E` out 2: operand source selects.
- `mc_busy` out 1: scoreboard entry valid.
- `mc_error` out 1: sticky timeout flag.
- `stall_cnt`, `flush_cnt` out `CNT_W`: saturating event counters.

## Operation
- Forwarding, per operand (A shown, B uses `rs2_E`):
  - `FWD_M` (2'b10) if `regWrite_M && rd_M!=0 && rd_M==rs1_E`;
  - else `FWD_W` (2'b01) if the same condition holds for W;
  - else `FWD_NONE` (2'b00). M wins over W.
- Load-use hazard: `resultSrc_E==2'b01 && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D)`.
- Launch hazard: `mc_start_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D || rd_E==rd_D)`.
- Scoreboard hazard: state BUSY and any of:
  - `mc_op_D` (structural);
  - `mc_rd!=0` and `mc_rd` equals `rs1_D` or `rs2_D` (RAW);
  - `mc_rd!=0` and `mc_rd` equals `rd_D` (WAW).
- Any hazard with `pcSrc_E==0` causes `stall_F=stall_D=flush_E=1` (bubble).
- `pcSrc_E==1` causes `flush_D=flush_E=1` and `stall_F=stall_D=0`. It overrides every hazard, because the D instruction is wrong-path.
- State machine (`mc_state_t`), two states:
  - IDLE to BUSY on `mc_start_E`; capture `mc_rd<=rd_E`; clear timer.
  - BUSY to IDLE on `mc_done`, or when timer reaches `MC_TIMEOUT-1`. On timeout, set `mc_error`.
  - In BUSY, the timer increments each cycle.
  - `mc_done` in IDLE is ignored.
  - `mc_start_E` in BUSY cannot occur, since the structural stall prevents it. If it does occur, it is ignored and `mc_error` is set.
- `mc_busy` equals `state==BUSY`.
- Counters:
  - `stall_cnt` +1 per cycle with `stall_D`.
  - `flush_cnt` +1 per cycle with `flush_D`.
  - Both saturate at all-ones.
- Reset values: state IDLE, `mc_rd=0`, timer 0, `mc_error=0`, both counters 0.
- Combinational outputs under reset follow their inputs, except that scoreboard hazards are inactive because state is IDLE.

## Timing
- Forwarding, stall and flush outputs have zero latency (same-cycle combinational).
- The scoreboard stall covers the `mc_done` cycle. It releases in the first cycle after `mc_done`, once the register file holds the result.
- Launch and `mc_done` can never coincide; unit latency is at least 2.
- `reset` asserted mid-BUSY clears the scoreboard immediately (asynchronous). The in-flight op is abandoned.
- `mc_error` clears only on `reset`.

## Structure
- Shared package `riscv_pipe_pkg` holds:
  - `fwd_sel_t` (`FWD_NONE`, `FWD_W`, `FWD_M`);
  - `RESULT_SRC_LOAD = 2'b01`;
  - `mc_state_t` (`MC_IDLE`, `MC_BUSY`).
- One natural sub-module: `mc_scoreboard`. It contains the FSM, `mc_rd`, the timer and `mc_error`, and outputs `mc_busy` and `mc_rd`.
- `hazard_ctrl` keeps forwarding, the hazard combine logic and the counters.

## Test plan
- Load-use: load with `rd_E=5`, `resultSrc_E=01`, `rs1_D=5` -> `stall_F=stall_D=flush_E=1` for 1 cycle; `stall_cnt` 0 to 1.
- Forward priority: `rs1_E=3`, `rd_M=rd_W=3`, both `regWrite` set -> `forwardA_E=2'b10`. With `rd_M=0` -> `2'b01`. With `rs2_E=0` -> `forwardB_E=2'b00`.
- Branch over hazard: load-use condition plus `pcSrc_E=1` -> `flush_D=flush_E=1`, `stall_D=0`; `flush_cnt` +1.
- Scoreboard: `mc_start_E` with `rd_E=7`, then `rs2_D=7` and `mc_done` 4 cycles later -> `stall_D` high until the `mc_done` cycle inclusive, low the cycle after; `mc_busy` high for 4 cycles.
- Structural/WAW and timeout: BUSY with `mc_op_D=1` -> stall. BUSY with `rd_D=mc_rd` -> stall. No `mc_done` for 64 cycles -> IDLE and `mc_error=1` sticky.
- Async reset mid-BUSY: `reset` pulse between edges -> `mc_busy=0` immediately; counters 0; stalls drop.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types: forwarding selects, result-source encodings and the
// multi-cycle scoreboard state, plus the forwarding priority helper.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    // The memory stage holds the younger value, so it wins over writeback.
    function automatic fwd_sel_t fwdSelect(input logic       regWriteM,
                                           input logic [4:0] rdM,
                                           input logic       regWriteW,
                                           input logic [4:0] rdW,
                                           input logic [4:0] rsE);
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
            sel = FWD_M;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline fields seen by the hazard controller and the stall,
// flush, forwarding and status signals it returns.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

    logic [4:0]       rs1_D, rs2_D, rd_D;
    logic             mc_op_D;
    logic [4:0]       rs1_E, rs2_E, rd_E;
    logic [1:0]       resultSrc_E;
    logic             mc_start_E;
    logic             pcSrc_E;
    logic [4:0]       rd_M, rd_W;
    logic             regWrite_M, regWrite_W;
    logic             mc_done;
    logic             stall_F, stall_D;
    logic             flush_D, flush_E;
    logic [1:0]       forwardA_E, forwardB_E;
    logic             mc_busy;
    logic             mc_error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output rs1_D, rs2_D, rd_D, mc_op_D, rs1_E, rs2_E, rd_E, resultSrc_E,
               mc_start_E, pcSrc_E, rd_M, rd_W, regWrite_M, regWrite_W, mc_done,
        input  stall_F, stall_D, flush_D, flush_E, forwardA_E, forwardB_E,
               mc_busy, mc_error, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_D, rs2_D, rd_D, mc_op_D, rs1_E, rs2_E, rd_E, resultSrc_E,
               mc_start_E, pcSrc_E, rd_M, rd_W, regWrite_M, regWrite_W, mc_done,
        output stall_F, stall_D, flush_D, flush_E, forwardA_E, forwardB_E,
               mc_busy, mc_error, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_mc_scoreboard.sv
// One-entry scoreboard for the multi-cycle EX unit: tracks the in-flight
// destination register and aborts with a sticky error if the unit hangs.
module mc_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mcStart_i,
    input  logic [4:0] rdE_i,
    input  logic       mcDone_i,
    output logic       mcBusy_o,
    output logic [4:0] mcRd_o,
    output logic       mcError_o
);

    localparam logic [9:0] TIMER_LAST = 10'(MC_TIMEOUT - 1);

    mc_state_t  state_q, state_d;
    logic [4:0] mcRd_q, mcRd_d;
    logic [9:0] timer_q, timer_d;
    logic       error_q, error_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MC_IDLE;
            mcRd_q  <= 5'd0;
            timer_q <= 10'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcRd_q  <= mcRd_d;
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    // A completion that lands on the final timer cycle counts as success.
    always_comb begin
        state_d = state_q;
        mcRd_d  = mcRd_q;
        timer_d = timer_q;
        error_d = error_q;
        if (state_q == MC_IDLE) begin
            if (mcStart_i) begin
                state_d = MC_BUSY;
                mcRd_d  = rdE_i;
                timer_d = 10'd0;
            end
        end else begin
            if (mcStart_i) begin
                error_d = 1'b1;
            end
            if (mcDone_i) begin
                state_d = MC_IDLE;
            end else if (timer_q == TIMER_LAST) begin
                state_d = MC_IDLE;
                error_d = 1'b1;
            end else begin
                timer_d = timer_q + 10'd1;
            end
        end
    end

    assign mcBusy_o  = (state_q == MC_BUSY);
    assign mcRd_o    = mcRd_q;
    assign mcError_o = error_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use / launch / scoreboard
// bubbles, branch flushes and saturating stall/flush event counters.
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave bus
);

    logic             mcBusy;
    logic [4:0]       mcRd;
    logic             mcError;
    logic             loadUseHaz, launchHaz, sbHaz, anyHaz;
    logic             bubble;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    mc_scoreboard #(.MC_TIMEOUT(MC_TIMEOUT)) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .mcStart_i (bus.mc_start_E),
        .rdE_i     (bus.rd_E),
        .mcDone_i  (bus.mc_done),
        .mcBusy_o  (mcBusy),
        .mcRd_o    (mcRd),
        .mcError_o (mcError)
    );

    assign bus.forwardA_E = fwdSelect(bus.regWrite_M, bus.rd_M, bus.regWrite_W, bus.rd_W, bus.rs1_E);
    assign bus.forwardB_E = fwdSelect(bus.regWrite_M, bus.rd_M, bus.regWrite_W, bus.rd_W, bus.rs2_E);

    assign loadUseHaz = (bus.resultSrc_E == RESULT_SRC_LOAD) && (bus.rd_E != 5'd0) &&
                        ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D));
    assign launchHaz  = bus.mc_start_E && (bus.rd_E != 5'd0) &&
                        ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D) || (bus.rd_E == bus.rd_D));
    // Structural, RAW and WAW against the in-flight multi-cycle destination.
    assign sbHaz      = mcBusy && (bus.mc_op_D ||
                        ((mcRd != 5'd0) &&
                         ((mcRd == bus.rs1_D) || (mcRd == bus.rs2_D) || (mcRd == bus.rd_D))));
    assign anyHaz     = loadUseHaz || launchHaz || sbHaz;

    // A taken branch makes the decode instruction wrong-path, so no bubble.
    assign bubble      = anyHaz && !bus.pcSrc_E;
    assign bus.stall_F = bubble;
    assign bus.stall_D = bubble;
    assign bus.flush_D = bus.pcSrc_E;
    assign bus.flush_E = bus.pcSrc_E || bubble;

    assign bus.mc_busy  = mcBusy;
    assign bus.mc_error = mcError;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (bubble && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
        if (bus.pcSrc_E && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stallCnt_q;
    assign bus.flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations are queued as each step is
// driven and drained against the DUT half a cycle away from the clock edge.
module tb_hazard_ctrl;

    typedef enum int {
        S_STALLF, S_STALLD, S_FLUSHD, S_FLUSHE, S_FWDA, S_FWDB,
        S_BUSY, S_ERR, S_SCNT, S_FCNT
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    hazard_ctrl_if #(.CNT_W(3)) bus ();

    hazard_ctrl #(.MC_TIMEOUT(64), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input sig_e s);
        logic [31:0] v;
        v = 32'd0;
        case (s)
            S_STALLF: v = 32'(bus.stall_F);
            S_STALLD: v = 32'(bus.stall_D);
            S_FLUSHD: v = 32'(bus.flush_D);
            S_FLUSHE: v = 32'(bus.flush_E);
            S_FWDA:   v = 32'(bus.forwardA_E);
            S_FWDB:   v = 32'(bus.forwardB_E);
            S_BUSY:   v = 32'(bus.mc_busy);
            S_ERR:    v = 32'(bus.mc_error);
            S_SCNT:   v = 32'(bus.stall_cnt);
            S_FCNT:   v = 32'(bus.flush_cnt);
            default:  v = 32'hdead_beef;
        endcase
        return v;
    endfunction

    task automatic clearInputs();
        bus.rs1_D       = 5'd0;
        bus.rs2_D       = 5'd0;
        bus.rd_D        = 5'd0;
        bus.mc_op_D     = 1'b0;
        bus.rs1_E       = 5'd0;
        bus.rs2_E       = 5'd0;
        bus.rd_E        = 5'd0;
        bus.resultSrc_E = 2'b00;
        bus.mc_start_E  = 1'b0;
        bus.pcSrc_E     = 1'b0;
        bus.rd_M        = 5'd0;
        bus.rd_W        = 5'd0;
        bus.regWrite_M  = 1'b0;
        bus.regWrite_W  = 1'b0;
        bus.mc_done     = 1'b0;
    endtask

    // Each step starts at the falling edge so inputs are stable before the rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic expectOut(input string tag, input sig_e s, input logic [31:0] v);
        expQ.push_back('{tag: tag, sig: s, exp: v});
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = observe(e.sig);
            checkCount++;
            assert (obs === e.exp) passCount++;
            else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        bus.resultSrc_E = 2'b01;
        bus.rd_E        = 5'd5;
        bus.rs1_D       = 5'd5;
        expectOut("rst_stallD_follows", S_STALLD, 32'd1);
        expectOut("rst_busy",           S_BUSY,   32'd0);
        expectOut("rst_err",            S_ERR,    32'd0);
        expectOut("rst_scnt",           S_SCNT,   32'd0);
        expectOut("rst_fcnt",           S_FCNT,   32'd0);
        checkOutput();

        applyStimulus();
        reset = 1'b0;
        bus.resultSrc_E = 2'b01;
        bus.rd_E        = 5'd5;
        bus.rs1_D       = 5'd5;
        expectOut("lu_stallF", S_STALLF, 32'd1);
        expectOut("lu_stallD", S_STALLD, 32'd1);
        expectOut("lu_flushE", S_FLUSHE, 32'd1);
        expectOut("lu_flushD", S_FLUSHD, 32'd0);
        expectOut("lu_scnt0",  S_SCNT,   32'd0);
        checkOutput();

        applyStimulus();
        expectOut("lu_release", S_STALLD, 32'd0);
        expectOut("lu_flushE0", S_FLUSHE, 32'd0);
        expectOut("lu_scnt1",   S_SCNT,   32'd1);
        checkOutput();

        applyStimulus();
        bus.rs1_E = 5'd3; bus.rs2_E = 5'd0;
        bus.rd_M  = 5'd3; bus.rd_W  = 5'd3;
        bus.regWrite_M = 1'b1; bus.regWrite_W = 1'b1;
        expectOut("fwdA_M_wins", S_FWDA, 32'd2);
        expectOut("fwdB_x0",     S_FWDB, 32'd0);
        checkOutput();

        applyStimulus();
        bus.rs1_E = 5'd3; bus.rs2_E = 5'd3;
        bus.rd_M  = 5'd0; bus.rd_W  = 5'd3;
        bus.regWrite_M = 1'b1; bus.regWrite_W = 1'b1;
        expectOut("fwdA_W", S_FWDA, 32'd1);
        expectOut("fwdB_W", S_FWDB, 32'd1);
        checkOutput();

        applyStimulus();
        bus.resultSrc_E = 2'b01;
        bus.rd_E        = 5'd5;
        bus.rs1_D       = 5'd5;
        bus.pcSrc_E     = 1'b1;
        expectOut("br_flushD", S_FLUSHD, 32'd1);
        expectOut("br_flushE", S_FLUSHE, 32'd1);
        expectOut("br_stallD", S_STALLD, 32'd0);
        expectOut("br_stallF", S_STALLF, 32'd0);
        expectOut("br_fcnt0",  S_FCNT,   32'd0);
        checkOutput();

        applyStimulus();
        expectOut("br_fcnt1", S_FCNT,   32'd1);
        expectOut("br_scnt",  S_SCNT,   32'd1);
        expectOut("br_done",  S_FLUSHD, 32'd0);
        checkOutput();

        applyStimulus();
        bus.mc_start_E = 1'b1;
        bus.rd_E       = 5'd7;
        bus.rs2_D      = 5'd7;
        expectOut("launch_stallD", S_STALLD, 32'd1);
        expectOut("launch_busy0",  S_BUSY,   32'd0);
        checkOutput();

        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            bus.rs2_D   = 5'd7;
            bus.mc_done = (i == 4);
            expectOut($sformatf("sb_busy_c%0d", i),  S_BUSY,   32'd1);
            expectOut($sformatf("sb_stall_c%0d", i), S_STALLD, 32'd1);
            checkOutput();
        end

        applyStimulus();
        bus.rs2_D = 5'd7;
        expectOut("sb_busy_after",  S_BUSY,   32'd0);
        expectOut("sb_stall_after", S_STALLD, 32'd0);
        expectOut("sb_scnt6",       S_SCNT,   32'd6);
        checkOutput();

        applyStimulus();
        bus.mc_start_E = 1'b1;
        bus.rd_E       = 5'd9;
        expectOut("launch2_nostall", S_STALLD, 32'd0);
        checkOutput();

        applyStimulus();
        bus.mc_op_D = 1'b1;
        expectOut("struct_busy",  S_BUSY,   32'd1);
        expectOut("struct_stall", S_STALLD, 32'd1);
        checkOutput();

        applyStimulus();
        bus.rd_D = 5'd9;
        expectOut("waw_stall", S_STALLD, 32'd1);
        checkOutput();

        applyStimulus();
        expectOut("busy_nohaz", S_STALLD, 32'd0);
        expectOut("busy_c3",    S_BUSY,   32'd1);
        checkOutput();

        for (int i = 0; i < 60; i++) begin
            applyStimulus();
            checkOutput();
        end

        applyStimulus();
        expectOut("to_last_busy", S_BUSY, 32'd1);
        expectOut("to_last_err",  S_ERR,  32'd0);
        checkOutput();

        applyStimulus();
        expectOut("to_idle",  S_BUSY, 32'd0);
        expectOut("to_err",   S_ERR,  32'd1);
        expectOut("scnt_sat", S_SCNT, 32'd7);
        checkOutput();

        applyStimulus();
        bus.mc_done = 1'b1;
        expectOut("idle_done_ignored", S_BUSY, 32'd0);
        expectOut("err_sticky",        S_ERR,  32'd1);
        checkOutput();

        applyStimulus();
        bus.mc_start_E = 1'b1;
        bus.rd_E       = 5'd4;
        expectOut("launch3_nostall", S_STALLD, 32'd0);
        checkOutput();

        applyStimulus();
        bus.rs1_D = 5'd4;
        expectOut("raw_busy",  S_BUSY,   32'd1);
        expectOut("raw_stall", S_STALLD, 32'd1);
        checkOutput();
        #1 reset = 1'b1;
        expectOut("arst_busy",  S_BUSY,   32'd0);
        expectOut("arst_stall", S_STALLD, 32'd0);
        expectOut("arst_err",   S_ERR,    32'd0);
        expectOut("arst_scnt",  S_SCNT,   32'd0);
        expectOut("arst_fcnt",  S_FCNT,   32'd0);
        checkOutput();

        applyStimulus();
        reset = 1'b0;
        bus.rs1_D = 5'd4;
        expectOut("post_rst_busy",  S_BUSY,   32'd0);
        expectOut("post_rst_stall", S_STALLD, 32'd0);
        expectOut("post_rst_scnt",  S_SCNT,   32'd0);
        checkOutput();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
